// File: rtl/sample_framer_fifo.sv
// UART byte stream -> little-endian sample assembler -> FIFO -> one sample per DAC tick.
// A prime/play FSM holds off playback until the FIFO has PRIME_LEVEL samples buffered.
module sample_framer_fifo #(
  parameter int SAMPLE_WIDTH = 18,
  parameter int SAMPLE_BYTES = 3,
  parameter int FIFO_DEPTH   = 16,
  parameter int PRIME_LEVEL  = 8,
  parameter int BYTE_TIMEOUT = 2000,
  parameter logic [SAMPLE_WIDTH-1:0] RESET_SAMPLE = '0
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            rx_valid,
  input  logic [7:0]                      rx_byte,
  input  logic                            sample_tick,
  input  logic                            clear_flags,
  output logic [SAMPLE_WIDTH-1:0]         sample_out,
  output logic                            sample_strobe,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic                            playing,
  output logic                            overflow,
  output logic                            underrun,
  output logic                            frame_error
);
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int LW     = AW + 1;
  localparam int IW     = (SAMPLE_BYTES > 1) ? $clog2(SAMPLE_BYTES) : 1;
  localparam int TW     = $clog2(BYTE_TIMEOUT + 1);
  localparam int LAST_W = SAMPLE_WIDTH - 8 * (SAMPLE_BYTES - 1);

  localparam logic [0:0] ST_PRIME = 1'b0;
  localparam logic [0:0] ST_PLAY  = 1'b1;

  // Only the leading bytes are stored; the last byte is taken straight from rx_byte.
  logic [SAMPLE_BYTES-2:0][7:0] asm_q, asm_d;
  logic [IW-1:0]                idx_q, idx_d, eff_idx;
  logic [TW-1:0]                tmo_q, tmo_d;
  logic                         tmo_hit, push_req, push, pop, empty, full, tick_play;
  logic [SAMPLE_WIDTH-1:0]      push_word;

  logic [SAMPLE_WIDTH-1:0]      mem [FIFO_DEPTH];
  logic [LW-1:0]                wr_q, wr_d, rd_q, rd_d, level_q, level_d;
  logic [0:0]                   state_q, state_d;
  logic [SAMPLE_WIDTH-1:0]      sample_q, sample_d;
  logic                         strobe_q, strobe_d;
  logic                         ovf_q, ovf_d, und_q, und_d, ferr_q, ferr_d;

  always_comb begin
    tmo_hit  = (idx_q != '0) && (tmo_q == TW'(BYTE_TIMEOUT));
    // A byte landing on the timeout cycle starts a fresh sample.
    eff_idx  = tmo_hit ? '0 : idx_q;
    asm_d    = asm_q;
    idx_d    = idx_q;
    tmo_d    = tmo_q;
    push_req = 1'b0;
    if (tmo_hit) begin
      idx_d = '0;
      tmo_d = '0;
    end else if (idx_q != '0 && !rx_valid) begin
      tmo_d = tmo_q + 1'b1;
    end
    if (rx_valid) begin
      tmo_d = '0;
      if (eff_idx == IW'(SAMPLE_BYTES - 1)) begin
        idx_d    = '0;
        push_req = 1'b1;
      end else begin
        idx_d = eff_idx + 1'b1;
        for (int k = 0; k < SAMPLE_BYTES - 1; k++)
          if (eff_idx == IW'(k)) asm_d[k] = rx_byte;
      end
    end
    push_word = {rx_byte[LAST_W-1:0], asm_q};
  end

  always_comb begin
    empty     = (level_q == '0);
    full      = (level_q == LW'(FIFO_DEPTH));
    tick_play = (state_q == ST_PLAY) && sample_tick;
    pop       = tick_play && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    push      = push_req && (!full || pop);
    wr_d      = wr_q + LW'(push);
    rd_d      = rd_q + LW'(pop);
    level_d   = wr_d - rd_d;
    sample_d  = pop ? mem[rd_q[AW-1:0]] : sample_q;
    strobe_d  = pop;
    ovf_d     = (push_req && full && !pop) || (ovf_q && !clear_flags);
    und_d     = (tick_play && empty) || (und_q && !clear_flags);
    ferr_d    = tmo_hit || (ferr_q && !clear_flags);
    state_d   = state_q;
    case (state_q)
      ST_PRIME: if (level_q >= LW'(PRIME_LEVEL)) state_d = ST_PLAY;
      default:  if (tick_play && empty)          state_d = ST_PRIME;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_q[AW-1:0]] <= push_word;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      asm_q    <= '0;
      idx_q    <= '0;
      tmo_q    <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      level_q  <= '0;
      state_q  <= ST_PRIME;
      sample_q <= RESET_SAMPLE;
      strobe_q <= 1'b0;
      ovf_q    <= 1'b0;
      und_q    <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      asm_q    <= asm_d;
      idx_q    <= idx_d;
      tmo_q    <= tmo_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      level_q  <= level_d;
      state_q  <= state_d;
      sample_q <= sample_d;
      strobe_q <= strobe_d;
      ovf_q    <= ovf_d;
      und_q    <= und_d;
      ferr_q   <= ferr_d;
    end
  end

  assign sample_out    = sample_q;
  assign sample_strobe = strobe_q;
  assign fifo_level    = level_q;
  assign playing       = (state_q == ST_PLAY);
  assign overflow      = ovf_q;
  assign underrun      = und_q;
  assign frame_error   = ferr_q;
endmodule

// File: tb/tb_sample_framer_fifo.sv
// Directed bench for sample_framer_fifo: stimulus pushes expected samples into a
// queue and a negedge monitor compares them against each sample_strobe.
module tb_sample_framer_fifo;
  localparam int TMO = 2000;

  logic        clk = 1'b0, reset_n = 1'b0;
  logic        rx_valid = 1'b0, sample_tick = 1'b0, clear_flags = 1'b0;
  logic [7:0]  rx_byte = '0;
  logic [17:0] sample_out;
  logic        sample_strobe, playing, overflow, underrun, frame_error;
  logic [4:0]  fifo_level;

  int pass_cnt = 0, total_cnt = 0, strobe_cnt = 0, s0;
  logic [17:0] exp_q[$];

  sample_framer_fifo dut (
    .clk(clk), .reset_n(reset_n), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .sample_tick(sample_tick), .clear_flags(clear_flags),
    .sample_out(sample_out), .sample_strobe(sample_strobe), .fifo_level(fifo_level),
    .playing(playing), .overflow(overflow), .underrun(underrun), .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (reset_n && sample_strobe) begin
      strobe_cnt++;
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL strobe_no_expected: got sample 0x%0h, none expected", sample_out);
      end else begin
        chk("sb_sample", sample_out, exp_q.pop_front());
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1; rx_byte = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_sample(input logic [17:0] w);
    send_byte(w[7:0]);
    send_byte(w[15:8]);
    send_byte({6'b0, w[17:16]});
    exp_q.push_back(w);
  endtask

  task automatic tick();
    sample_tick = 1'b1;
    @(posedge clk); #1;
    sample_tick = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;
    cyc(1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    @(posedge clk); #1;
    chk("rst_sample_out", sample_out, 0);
    chk("rst_strobe", sample_strobe, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_playing", playing, 0);
    chk("rst_flags", {overflow, underrun, frame_error}, 0);
    reset_n = 1'b1;
    cyc(1);

    // 1: prime with 0x31234 and play the first sample
    for (int i = 0; i < 7; i++) send_sample(18'h31234);
    chk("t1_prime_7", playing, 0);
    send_byte(8'h34); send_byte(8'h12);
    chk("t1_prime_partial", playing, 0);
    send_byte(8'h03); exp_q.push_back(18'h31234);
    chk("t1_level8", fifo_level, 8);
    cyc(1);
    chk("t1_playing", playing, 1);
    sample_tick = 1'b1;
    @(posedge clk); #1;
    sample_tick = 1'b0;
    chk("t1_strobe", sample_strobe, 1);
    chk("t1_sample", sample_out, 18'h31234);
    chk("t1_level7", fifo_level, 7);
    cyc(1);
    chk("t1_strobe_1cyc", sample_strobe, 0);

    // 2+5: last byte 0xFF truncation, then underrun and re-prime
    do_reset();
    send_byte(8'h56); send_byte(8'h34); send_byte(8'hFF);
    exp_q.push_back(18'h33456);
    for (int k = 1; k < 8; k++) send_sample(18'(k * 18'h1111));
    cyc(1);
    s0 = strobe_cnt;
    for (int k = 0; k < 8; k++) tick();
    chk("t5_strobes8", strobe_cnt - s0, 8);
    chk("t5_no_underrun_yet", underrun, 0);
    tick();
    chk("t5_strobes_still8", strobe_cnt - s0, 8);
    chk("t5_underrun", underrun, 1);
    chk("t5_hold", sample_out, 18'h07777);
    chk("t5_playing0", playing, 0);
    for (int k = 0; k < 8; k++) send_sample(18'(18'h20000 + k));
    cyc(1);
    chk("t5_replay", playing, 1);
    tick();
    chk("t5_resume", strobe_cnt - s0, 9);
    chk("t5_underrun_sticky", underrun, 1);
    clear_flags = 1'b1; cyc(1); clear_flags = 1'b0;
    chk("t5_underrun_clr", underrun, 0);

    // 3: partial-sample timeout
    do_reset();
    send_byte(8'hAA);
    cyc(TMO + 5);
    chk("t3_frame_error", frame_error, 1);
    chk("t3_level0", fifo_level, 0);
    send_sample(18'h00201);
    chk("t3_level1", fifo_level, 1);
    for (int k = 1; k < 8; k++) send_sample(18'(18'h10000 + k));
    cyc(1);
    tick();
    clear_flags = 1'b1; cyc(1); clear_flags = 1'b0;
    chk("t3_ferr_clr", frame_error, 0);

    // 4: overflow, set-beats-clear, push+pop when full
    do_reset();
    for (int k = 0; k < 16; k++) send_sample(18'(k * 18'h1001 + 5));
    chk("t4_level16", fifo_level, 16);
    chk("t4_no_ovf", overflow, 0);
    send_byte(8'hFF); send_byte(8'hFF);
    rx_valid = 1'b1; rx_byte = 8'h03; clear_flags = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0; clear_flags = 1'b0;
    chk("t4_ovf_set_wins", overflow, 1);
    chk("t4_level_held", fifo_level, 16);
    clear_flags = 1'b1; cyc(1); clear_flags = 1'b0;
    chk("t4_ovf_clr", overflow, 0);
    send_byte(8'hEF); send_byte(8'hBE);
    rx_valid = 1'b1; rx_byte = 8'h02; sample_tick = 1'b1;
    exp_q.push_back(18'h2BEEF);
    @(posedge clk); #1;
    rx_valid = 1'b0; sample_tick = 1'b0;
    chk("t4_pushpop_level", fifo_level, 16);
    chk("t4_pushpop_no_ovf", overflow, 0);
    cyc(1);
    for (int k = 0; k < 16; k++) tick();
    chk("t4_drained", fifo_level, 0);
    chk("t4_queue_done", exp_q.size(), 0);

    // 6: async reset mid-assembly and mid-play
    do_reset();
    for (int k = 0; k < 8; k++) send_sample(18'(18'h00100 + k));
    cyc(1);
    for (int k = 0; k < 3; k++) tick();
    chk("t6_level5", fifo_level, 5);
    send_byte(8'h77);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_rst_sample", sample_out, 0);
    chk("t6_rst_level", fifo_level, 0);
    chk("t6_rst_playing", playing, 0);
    chk("t6_rst_strobe", sample_strobe, 0);
    exp_q.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;
    cyc(1);
    send_sample(18'h14321);
    chk("t6_level1", fifo_level, 1);
    for (int k = 1; k < 8; k++) send_sample(18'(18'h30000 + k));
    cyc(1);
    for (int k = 0; k < 8; k++) tick();
    chk("t6_queue_done", exp_q.size(), 0);
    chk("t6_flags_clean", {overflow, underrun, frame_error}, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
